// File: rtl/jogador_auto.sv
// jogador_auto: tic-tac-toe auto player that scans for a win, then a block, then a free cell.
// Optional feature macro: JOGADOR_BLOQUEIO_EN compiles in the BLOQUEIO (block opponent) scan.
module jogador_auto #(
  parameter logic [1:0] SIMBOLO = 2'b10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] tabuleiro,
  input  logic        vez,
  input  logic        aceita,
  output logic [1:0]  posicaoX,
  output logic [1:0]  posicaoY,
  output logic        jogada_valida,
  output logic        cheio,
  output logic        ocupado
);
  localparam int unsigned NCEL = 9;
  localparam int unsigned CW   = 4;
  localparam int unsigned TW   = 2 * NCEL;
  localparam int unsigned LW   = 3;
  localparam logic [1:0]  VAZIO = 2'b00;
  localparam logic [CW-1:0] ORDEM [NCEL] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8,
                                              4'd1, 4'd3, 4'd5, 4'd7};

  typedef enum logic [2:0] {OCIOSO, VITORIA, BLOQUEIO, LIVRE, EMITE} estado_t;

  estado_t       estado;
  logic [TW-1:0] copia;
  logic [LW-1:0] indice;

  logic [1:0]    cel [NCEL];
  logic [CW-1:0] c0_c, c1_c, c2_c;
  logic [1:0]    alvo_c;
  logic          acerto_c;
  logic [CW-1:0] acerto_cel_c;
  logic          livre_ok_c;
  logic [CW-1:0] livre_cel_c;

  function automatic logic [1:0] coluna(input logic [CW-1:0] c);
    return 2'(c % CW'(3));
  endfunction

  function automatic logic [1:0] linha(input logic [CW-1:0] c);
    return 2'(c / CW'(3));
  endfunction

  always_comb begin
    for (int i = 0; i < int'(NCEL); i++) cel[i] = copia[2*i +: 2];
  end

  // Cells of the line under evaluation: rows, columns, main and anti diagonal.
  always_comb begin
    case (indice)
      3'd0:    {c0_c, c1_c, c2_c} = {4'd0, 4'd1, 4'd2};
      3'd1:    {c0_c, c1_c, c2_c} = {4'd3, 4'd4, 4'd5};
      3'd2:    {c0_c, c1_c, c2_c} = {4'd6, 4'd7, 4'd8};
      3'd3:    {c0_c, c1_c, c2_c} = {4'd0, 4'd3, 4'd6};
      3'd4:    {c0_c, c1_c, c2_c} = {4'd1, 4'd4, 4'd7};
      3'd5:    {c0_c, c1_c, c2_c} = {4'd2, 4'd5, 4'd8};
      3'd6:    {c0_c, c1_c, c2_c} = {4'd0, 4'd4, 4'd8};
      default: {c0_c, c1_c, c2_c} = {4'd2, 4'd4, 4'd6};
    endcase
  end

  // Two cells of the target code plus one empty cell on the current line.
  always_comb begin
    alvo_c = SIMBOLO;
`ifdef JOGADOR_BLOQUEIO_EN
    if (estado == BLOQUEIO) alvo_c = SIMBOLO ^ 2'b11;
`endif
    acerto_c     = 1'b0;
    acerto_cel_c = c0_c;
    if (cel[c1_c] == alvo_c && cel[c2_c] == alvo_c && cel[c0_c] == VAZIO) begin
      acerto_c     = 1'b1;
      acerto_cel_c = c0_c;
    end else if (cel[c0_c] == alvo_c && cel[c2_c] == alvo_c && cel[c1_c] == VAZIO) begin
      acerto_c     = 1'b1;
      acerto_cel_c = c1_c;
    end else if (cel[c0_c] == alvo_c && cel[c1_c] == alvo_c && cel[c2_c] == VAZIO) begin
      acerto_c     = 1'b1;
      acerto_cel_c = c2_c;
    end
  end

  // Walk the priority list backwards so the highest-priority empty cell wins.
  always_comb begin
    livre_ok_c  = 1'b0;
    livre_cel_c = '0;
    for (int i = int'(NCEL) - 1; i >= 0; i--) begin
      if (cel[ORDEM[i]] == VAZIO) begin
        livre_ok_c  = 1'b1;
        livre_cel_c = ORDEM[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= OCIOSO;
      indice        <= '0;
      posicaoX      <= '0;
      posicaoY      <= '0;
      jogada_valida <= 1'b0;
      cheio         <= 1'b0;
      ocupado       <= 1'b0;
      copia         <= '0;
    end else begin
      cheio <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (vez) begin
            copia   <= tabuleiro;
            indice  <= '0;
            estado  <= VITORIA;
            ocupado <= 1'b1;
          end
        end
        VITORIA: begin
          if (acerto_c) begin
            posicaoX      <= coluna(acerto_cel_c);
            posicaoY      <= linha(acerto_cel_c);
            jogada_valida <= 1'b1;
            estado        <= EMITE;
          end else begin
            indice <= LW'(indice + LW'(1));
`ifdef JOGADOR_BLOQUEIO_EN
            if (indice == LW'(7)) estado <= BLOQUEIO;
`else
            if (indice == LW'(7)) estado <= LIVRE;
`endif
          end
        end
`ifdef JOGADOR_BLOQUEIO_EN
        BLOQUEIO: begin
          if (acerto_c) begin
            posicaoX      <= coluna(acerto_cel_c);
            posicaoY      <= linha(acerto_cel_c);
            jogada_valida <= 1'b1;
            estado        <= EMITE;
          end else begin
            indice <= LW'(indice + LW'(1));
            if (indice == LW'(7)) estado <= LIVRE;
          end
        end
`endif
        LIVRE: begin
          if (livre_ok_c) begin
            posicaoX      <= coluna(livre_cel_c);
            posicaoY      <= linha(livre_cel_c);
            jogada_valida <= 1'b1;
            estado        <= EMITE;
          end else begin
            cheio   <= 1'b1;
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end
        end
        EMITE: begin
          if (aceita) begin
            jogada_valida <= 1'b0;
            estado        <= OCIOSO;
            ocupado       <= 1'b0;
          end
        end
        default: begin
          estado        <= OCIOSO;
          jogada_valida <= 1'b0;
          ocupado       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jogador_auto.sv
// tb_jogador_auto: randomized boards checked against a line/priority reference model.
module tb_jogador_auto;
  localparam logic [1:0] SIM = 2'b10;
  localparam logic [1:0] OPO = 2'b01;
`ifdef JOGADOR_BLOQUEIO_EN
  localparam bit BLQ = 1'b1;
`else
  localparam bit BLQ = 1'b0;
`endif
  localparam int LINHAS [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                   '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  localparam int ORDEM [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] tabuleiro;
  logic        vez;
  logic        aceita;
  logic [1:0]  posicaoX;
  logic [1:0]  posicaoY;
  logic        jogada_valida;
  logic        cheio;
  logic        ocupado;

  int erros  = 0;
  int checks = 0;

  jogador_auto #(.SIMBOLO(SIM)) dut (
    .clock(clock), .reset(reset), .tabuleiro(tabuleiro), .vez(vez), .aceita(aceita),
    .posicaoX(posicaoX), .posicaoY(posicaoY), .jogada_valida(jogada_valida),
    .cheio(cheio), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [1:0] cel_de(input logic [17:0] t, input int i);
    return t[2*i +: 2];
  endfunction

  function automatic logic [17:0] poe(input logic [17:0] t, input int i, input logic [1:0] v);
    logic [17:0] r;
    r = t;
    r[2*i +: 2] = v;
    return r;
  endfunction

  // Reference: win lines, then block lines, then priority list; latency in edges after vez.
  function automatic void modelo(input logic [17:0] t, output int lat, output bit full,
                                 output int pos);
    int passes, nal, nvz, vz, c;
    logic [1:0] alvo;
    passes = BLQ ? 2 : 1;
    lat = 0; full = 1'b0; pos = 0;
    for (int p = 0; p < passes; p++) begin
      alvo = (p == 0) ? SIM : OPO;
      for (int k = 0; k < 8; k++) begin
        nal = 0; nvz = 0; vz = 0;
        for (int j = 0; j < 3; j++) begin
          c = LINHAS[k][j];
          if (cel_de(t, c) == alvo) nal++;
          else if (cel_de(t, c) == 2'b00) begin nvz++; vz = c; end
        end
        if (nal == 2 && nvz == 1) begin
          lat = 8 * p + k + 1;
          pos = vz;
          return;
        end
      end
    end
    lat  = 8 * passes + 1;
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (full && cel_de(t, ORDEM[i]) == 2'b00) begin
        full = 1'b0;
        pos  = ORDEM[i];
      end
    end
  endfunction

  function automatic logic [17:0] sorteia(input bit lotado);
    logic [17:0] t;
    int r;
    t = '0;
    for (int i = 0; i < 9; i++) begin
      r = $urandom_range(0, 9);
      if (lotado) t = poe(t, i, r < 5 ? 2'b01 : (r < 9 ? 2'b10 : 2'b11));
      else        t = poe(t, i, r < 5 ? 2'b00 : (r < 7 ? 2'b01 : (r < 9 ? 2'b10 : 2'b11)));
    end
    return t;
  endfunction

  // One full request: scan with noisy inputs, then handshake (early or delayed aceita).
  task automatic jogada(input logic [17:0] t, input bit cedo);
    int lat, pos;
    bit full;
    modelo(t, lat, full, pos);
    tabuleiro = t;
    vez = 1'b1;
    tick();
    vez = 1'b0;
    verifica("ocupado_e0", ocupado, 1);
    for (int n = 1; n <= lat; n++) begin
      tabuleiro = 18'($urandom);
      vez = (n < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (cedo && n == lat) aceita = 1'b1;
      tick();
      if (n < lat) begin
        verifica("valid_scan", jogada_valida, 0);
        verifica("ocupado_scan", ocupado, 1);
        verifica("cheio_scan", cheio, 0);
      end
    end
    vez = 1'b0;
    if (full) begin
      verifica("cheio_pulse", cheio, 1);
      verifica("valid_full", jogada_valida, 0);
      verifica("ocupado_full", ocupado, 0);
      tick();
      verifica("cheio_end", cheio, 0);
      verifica("valid_full2", jogada_valida, 0);
      verifica("ocupado_full2", ocupado, 0);
    end else begin
      verifica("valid_set", jogada_valida, 1);
      verifica("pos_x", posicaoX, pos % 3);
      verifica("pos_y", posicaoY, pos / 3);
      verifica("cheio_move", cheio, 0);
      if (!cedo) begin
        repeat ($urandom_range(0, 4)) begin
          vez = 1'($urandom_range(0, 1));
          tick();
          verifica("valid_hold", jogada_valida, 1);
          verifica("x_hold", posicaoX, pos % 3);
          verifica("y_hold", posicaoY, pos / 3);
          verifica("ocupado_hold", ocupado, 1);
        end
        vez = 1'b0;
        aceita = 1'b1;
      end
      tick();
      verifica("valid_ack", jogada_valida, 0);
      verifica("ocupado_ack", ocupado, 0);
      verifica("x_keep", posicaoX, pos % 3);
      verifica("y_keep", posicaoY, pos / 3);
    end
    // Idle aceita must be ignored.
    aceita = 1'b1;
    tick();
    aceita = 1'b0;
    verifica("idle_valid", jogada_valida, 0);
    verifica("idle_ocupado", ocupado, 0);
    if (!full) begin
      verifica("idle_x", posicaoX, pos % 3);
      verifica("idle_y", posicaoY, pos / 3);
    end
  endtask

  initial begin
    logic [17:0] t;
    reset = 1'b1; vez = 1'b0; aceita = 1'b0; tabuleiro = '0;
    tick();
    tick();
    verifica("rst_valid", jogada_valida, 0);
    verifica("rst_cheio", cheio, 0);
    verifica("rst_ocupado", ocupado, 0);
    verifica("rst_x", posicaoX, 0);
    verifica("rst_y", posicaoY, 0);
    reset = 1'b0;
    tick();

    // Win on line 0 at cell 2.
    t = poe(poe(18'h0, 0, SIM), 1, SIM);
    jogada(t, 1'b0);
    // Opponent threat on row 1.
    t = poe(poe(poe(18'h0, 3, OPO), 4, OPO), 0, SIM);
    jogada(t, 1'b0);
    // Free choice: empty board, then centre taken.
    jogada(18'h0, 1'b0);
    jogada(poe(18'h0, 4, 2'b11), 1'b1);
    // Full board.
    jogada(18'h1_6969, 1'b0);
    // Win on the anti-diagonal (line 7).
    t = poe(poe(18'h0, 2, SIM), 6, SIM);
    jogada(t, 1'b1);

    // Reset in the middle of a scan, then restart.
    jogada(poe(poe(18'h0, 0, SIM), 1, SIM), 1'b0);
    tabuleiro = '0;
    vez = 1'b1;
    tick();
    vez = 1'b0;
    repeat (4) tick();
    reset = 1'b1; vez = 1'b1; aceita = 1'b1;
    tick();
    reset = 1'b0; vez = 1'b0; aceita = 1'b0;
    verifica("mid_rst_valid", jogada_valida, 0);
    verifica("mid_rst_cheio", cheio, 0);
    verifica("mid_rst_ocupado", ocupado, 0);
    verifica("mid_rst_x", posicaoX, 0);
    verifica("mid_rst_y", posicaoY, 0);
    jogada(18'h0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      jogada(sorteia($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end
endmodule

// File: doc/jogador_auto.md
JOGADOR_AUTO -- requirements
Module: jogador_auto

Interface
REQ-001 The block SHALL have parameter SIMBOLO, default 2'b10, the cell code the block plays (2'b01 = X, 2'b10 = O).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset. The clock port is `clock` and the reset port is `reset`.
REQ-003 The block SHALL have port `clock`, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port `reset`, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port `tabuleiro`, input, 18 bits: board state. Cell i (i = 3*y + x) occupies bits [2i+1:2i]. Code 00 = empty, 01 = X, 10 = O, 11 = occupied/foreign.
REQ-006 The block SHALL have port `vez`, input, 1 bit: one-cycle request to compute a move.
REQ-007 The block SHALL have port `aceita`, input, 1 bit: the game acknowledges the offered move.
REQ-008 The block SHALL have port `posicaoX`, output, 2 bits: column of the chosen move (0..2).
REQ-009 The block SHALL have port `posicaoY`, output, 2 bits: row of the chosen move (0..2).
REQ-010 The block SHALL have port `jogada_valida`, output, 1 bit: posicaoX/posicaoY hold a valid offered move.
REQ-011 The block SHALL have port `cheio`, output, 1 bit: one-cycle pulse when no empty cell exists.
REQ-012 The block SHALL have port `ocupado`, output, 1 bit: high whenever the FSM is not in OCIOSO.

Function
REQ-013 The FSM SHALL have exactly these states: OCIOSO, VITORIA, BLOQUEIO, LIVRE, EMITE.
REQ-014 In OCIOSO, `vez`=1 at edge E0 SHALL latch `tabuleiro` into an internal copy, set line index to 0 and enter VITORIA. All later evaluation SHALL use the latched copy only.
REQ-015 `vez` SHALL be ignored in every state except OCIOSO.
REQ-016 Lines SHALL be indexed 0-2 for rows y=0..2, 3-5 for columns x=0..2, 6 for the main diagonal (0,4,8) and 7 for the anti-diagonal (2,4,6).
REQ-017 VITORIA SHALL evaluate one line per cycle. A hit is two cells equal to SIMBOLO and the third cell 00.
REQ-018 On a hit, the block SHALL load the empty cell's x/y into posicaoX/posicaoY and go to EMITE. On a miss, it SHALL increment the index; after line 7 it SHALL reset the index to 0 and go to BLOQUEIO (or LIVRE, see REQ-030).
REQ-019 BLOQUEIO SHALL be identical to VITORIA, except a hit is two cells equal to the opponent code (SIMBOLO ^ 2'b11) and the third cell 00. After line 7 it SHALL go to LIVRE.
REQ-020 LIVRE SHALL take one cycle and pick the first 00 cell in priority order 4, 0, 2, 6, 8, 1, 3, 5, 7, then go to EMITE.
REQ-021 If LIVRE finds no 00 cell, the block SHALL pulse `cheio` high for exactly one cycle and return to OCIOSO with `jogada_valida`=0.
REQ-022 Timing from the `vez` edge E0:
  - a win on line k SHALL assert `jogada_valida` after edge E0+k+1;
  - a block on line k SHALL assert it after edge E0+9+k;
  - a LIVRE choice SHALL assert it after edge E0+17.
REQ-023 In EMITE, `jogada_valida` SHALL stay 1 and posicaoX/posicaoY SHALL stay stable until `aceita`=1 is sampled.
REQ-024 On that `aceita` edge, the block SHALL deassert `jogada_valida` and return to OCIOSO. posicaoX/posicaoY SHALL retain their values.
REQ-025 `aceita` SHALL be ignored outside EMITE.
REQ-026 If `aceita` is already high on EMITE entry, the handshake SHALL complete on the first EMITE edge, so `jogada_valida` is high for exactly one cycle.
REQ-027 Code 11 SHALL count as neither empty, own, nor opponent.

Reset
REQ-028 When `reset`=1 at a rising edge, the block SHALL clear the following, regardless of state (including mid-scan and mid-EMITE); reset SHALL take priority over `vez` and `aceita`:
  - FSM to OCIOSO;
  - line index to 0;
  - posicaoX and posicaoY to 0;
  - `jogada_valida`, `cheio` and `ocupado` to 0;
  - latched board to 0.
REQ-029 The block SHALL produce no output change without a clock edge, including on reset.

Configuration
REQ-030 Macro JOGADOR_BLOQUEIO_EN SHALL control the BLOQUEIO state.
  - Defined: BLOQUEIO SHALL be compiled in as specified.
  - Undefined: BLOQUEIO logic SHALL be absent, VITORIA line 7 miss SHALL go directly to LIVRE, and a LIVRE choice SHALL assert `jogada_valida` after edge E0+9.

Verification
REQ-031 Win: SIMBOLO=O, cells 0=O, 1=O, others 00, `vez` at E0 -> `jogada_valida` after E0+1 with X=2, Y=0. Hold `aceita`=0 for 5 cycles: outputs stable. Then `aceita`=1 -> `jogada_valida`=0 next edge.
REQ-032 Block (macro on): cells 3=X, 4=X, 0=O, others 00 -> after E0+10 (line 1), X=2, Y=1.
REQ-033 Free choice: empty board -> after E0+17 (macro on) or E0+9 (macro off), X=1, Y=1. Board with only cell 4 occupied -> X=0, Y=0.
REQ-034 Full board: all cells 01/10 with no empty cell -> `cheio`=1 for exactly one cycle, `jogada_valida` never set, `ocupado` returns to 0.
REQ-035 Reset mid-scan: `vez` at E0, `reset`=1 at E0+5 -> after E0+5 all outputs 0 and state OCIOSO. `vez` at E0+6 restarts the scan normally.
REQ-036 Ignored inputs: `vez` pulses during VITORIA and EMITE, and `aceita` pulses in OCIOSO -> no state or output change attributable to them.
